// File: rtl/hamming_pkg.sv
// Shared types and widths for the Hamming(7,4) encoder scheduler.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_OUT_LO  = 3'd3,
    ST_LOAD_HI = 3'd4,
    ST_WAIT_HI = 3'd5,
    ST_OUT_HI  = 3'd6
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The requester that did not win last
// time wins a tie; ready is a combinational pulse gated by the idle qualifier.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic       grant
);

  logic last_grant;

  // Grant selection and ready generation
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_grant : (req_valid[1] & ~req_valid[0]);
    req_ready = 2'b00;
    if (idle) req_ready[grant] = req_valid[grant];
  end

  // Remember the last winner; reset value 1 lets requester 0 win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last_grant <= 1'b1;
    else if (|req_ready) last_grant <= grant;
  end

endmodule

// File: rtl/hamming_enc_scheduler.sv
// Shares one Hamming(7,4) encoder between two byte requesters. Each byte is
// encoded as two nibbles (low first); codewords leave on a valid/ready port.
module hamming_enc_scheduler
  import hamming_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              enc_ena,
  output logic [DATA_W-1:0] enc_data,
  input  logic [CODE_W-1:0] enc_code,
  input  logic              enc_valid,
  output logic              cw_valid,
  output logic [CODE_W-1:0] cw_data,
  output logic              cw_src,
  output logic              cw_hi,
  input  logic              cw_ready,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [BYTE_W-1:0] byte_q;
  logic              src_q;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        rdy;
  logic              grant;
  logic              accept;
  logic              wd_fire;

  // Readies are forced low while reset is held so every output reads 0
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .idle      ((state == ST_IDLE) & ~rst),
    .req_valid ({req1_valid, req0_valid}),
    .req_ready (rdy),
    .grant     (grant)
  );

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign accept     = |rdy;
  assign busy       = (state != ST_IDLE);
  assign cw_data    = cw_valid ? code_q : '0;
  assign cw_src     = cw_valid & src_q;

  // Next-state and per-state outputs
  always_comb begin
    state_nx = state;
    enc_ena  = 1'b0;
    enc_data = '0;
    cw_valid = 1'b0;
    cw_hi    = 1'b0;
    wd_fire  = 1'b0;
    unique case (state)
      ST_IDLE:    if (accept) state_nx = ST_LOAD_LO;
      ST_LOAD_LO: begin
        enc_ena  = 1'b1;
        enc_data = byte_q[DATA_W-1:0];
        state_nx = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        enc_data = byte_q[DATA_W-1:0];
        if (enc_valid) state_nx = ST_OUT_LO;
        else if (cnt == CNT_LIM) begin
          wd_fire  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_OUT_LO: begin
        cw_valid = 1'b1;
        if (cw_ready) state_nx = ST_LOAD_HI;
      end
      ST_LOAD_HI: begin
        enc_ena  = 1'b1;
        enc_data = byte_q[BYTE_W-1:DATA_W];
        state_nx = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        enc_data = byte_q[BYTE_W-1:DATA_W];
        if (enc_valid) state_nx = ST_OUT_HI;
        else if (cnt == CNT_LIM) begin
          wd_fire  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_OUT_HI: begin
        cw_valid = 1'b1;
        cw_hi    = 1'b1;
        if (cw_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Byte/source capture, watchdog counter and codeword register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      src_q  <= 1'b0;
      code_q <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        byte_q <= grant ? req1_data : req0_data;
        src_q  <= grant;
      end
      if (state == ST_LOAD_LO || state == ST_LOAD_HI) cnt <= '0;
      else if (state == ST_WAIT_LO || state == ST_WAIT_HI) cnt <= cnt + 1'b1;
      if ((state == ST_WAIT_LO || state == ST_WAIT_HI) && enc_valid) code_q <= enc_code;
    end
  end

  // Sticky watchdog flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timeout_err <= 1'b0;
    else if (wd_fire) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// Bench for hamming_enc_scheduler: latency-1 encoder stub, acceptance-driven
// scoreboard, table vectors and hand sequences for the multi-cycle cases.
module tb_hamming_enc_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       enc_ena;
  logic [3:0] enc_data;
  logic [6:0] enc_code;
  logic       enc_valid;
  logic       cw_valid;
  logic [6:0] cw_data;
  logic       cw_src, cw_hi;
  logic       cw_ready = 1'b1;
  logic       busy, timeout_err;
  logic       err_clr = 1'b0;
  logic       mute = 1'b0;

  typedef struct packed {logic src; logic hi; logic [6:0] data;} cw_t;
  typedef struct {logic src; logic [7:0] data; logic [6:0] exp_lo; logic [6:0] exp_hi;} vec_t;

  cw_t sb[$], obs[$], cw_hist[$];
  int  cw_cyc[$];
  logic acc_log[$];
  int  cyc = 0, acc_cyc = 0, ena_cyc = 0;
  int  checks = 0, failures = 0;

  hamming_enc_scheduler #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .enc_ena(enc_ena), .enc_data(enc_data), .enc_code(enc_code), .enc_valid(enc_valid),
    .cw_valid(cw_valid), .cw_data(cw_data), .cw_src(cw_src), .cw_hi(cw_hi), .cw_ready(cw_ready),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder stub: one cycle latency, code = {3'b101, nibble}; mute withholds enc_valid
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid <= 1'b0;
      enc_code  <= '0;
    end else begin
      enc_valid <= enc_ena & ~mute;
      enc_code  <= {3'b101, enc_data};
    end
  end

  // Monitor: expected codewords are queued on acceptance, observed ones on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready) begin
        sb.push_back({1'b0, 1'b0, 3'b101, req0_data[3:0]});
        sb.push_back({1'b0, 1'b1, 3'b101, req0_data[7:4]});
        acc_log.push_back(1'b0);
        acc_cyc = cyc;
      end
      if (req1_ready) begin
        sb.push_back({1'b1, 1'b0, 3'b101, req1_data[3:0]});
        sb.push_back({1'b1, 1'b1, 3'b101, req1_data[7:4]});
        acc_log.push_back(1'b1);
        acc_cyc = cyc;
      end
      if (enc_ena) ena_cyc = cyc;
      if (cw_valid && cw_ready) begin
        obs.push_back({cw_src, cw_hi, cw_data});
        cw_hist.push_back({cw_src, cw_hi, cw_data});
        cw_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic src, input logic [7:0] d);
    int n0 = acc_log.size();
    int k = 0;
    if (src) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    while (acc_log.size() == n0 && k < 100) begin tick(); k++; end
    if (src) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("accept_seen", 32'(acc_log.size() > n0), 1);
  endtask

  task automatic wait_cw(input int target);
    int k = 0;
    while (cw_hist.size() < target && k < 300) begin tick(); k++; end
    chk("cw_count", 32'(cw_hist.size() >= target), 1);
  endtask

  task automatic check_sb();
    while (obs.size() > 0) begin
      cw_t o = obs.pop_front();
      if (sb.size() == 0) chk("sb_underflow", 32'(o), 32'h1ff);
      else                chk("sb_cw", 32'(o), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    vec_t tbl[4];
    logic [6:0] cont_exp[4];
    int t0, e0, a0, c0, k;
    logic [6:0] bp_data;

    tbl[0] = '{1'b1, 8'h00, 7'h50, 7'h50};
    tbl[1] = '{1'b0, 8'hFF, 7'h5F, 7'h5F};
    tbl[2] = '{1'b0, 8'h3C, 7'h5C, 7'h53};
    tbl[3] = '{1'b1, 8'h69, 7'h59, 7'h56};
    cont_exp[0] = 7'h52; cont_exp[1] = 7'h51; cont_exp[2] = 7'h54; cont_exp[3] = 7'h53;

    // Reset state
    #12;
    chk("rst_outs", {req0_ready, req1_ready, enc_ena, enc_data, cw_valid, cw_data, cw_src, cw_hi, busy, timeout_err}, 0);
    tick(); rst = 1'b0;
    tick();

    // Single byte timing: low at T+3, high at T+6, idle at T+7
    send(1'b0, 8'hA5);
    t0 = acc_cyc;
    wait_cw(2);
    chk("lo_cw", 32'(cw_hist[0]), {2'b00, 7'h55});
    chk("hi_cw", 32'(cw_hist[1]), {2'b01, 7'h5A});
    chk("lo_lat", 32'(cw_cyc[0] - t0), 3);
    chk("hi_lat", 32'(cw_cyc[1] - t0), 6);
    do @(negedge clk); while (cyc < t0 + 7);
    chk("busy_low", {busy, cw_valid}, 0);
    check_sb();

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      c0 = cw_hist.size();
      tick();
      send(tbl[i].src, tbl[i].data);
      wait_cw(c0 + 2);
      chk($sformatf("tbl%0d_lo", i), 32'(cw_hist[c0]),     {tbl[i].src, 1'b0, tbl[i].exp_lo});
      chk($sformatf("tbl%0d_hi", i), 32'(cw_hist[c0 + 1]), {tbl[i].src, 1'b1, tbl[i].exp_hi});
      check_sb();
    end

    // Both requesters valid continuously: strict alternation starting at req0
    tick();
    a0 = acc_log.size(); c0 = cw_hist.size();
    req0_data = 8'h12; req1_data = 8'h34;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    while (acc_log.size() < a0 + 4 && k < 200) begin tick(); k++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_accepts", 32'(acc_log.size() >= a0 + 4), 1);
    for (int i = 0; i < 4; i++)
      if (acc_log.size() > a0 + i) chk($sformatf("rr_order%0d", i), 32'(acc_log[a0 + i]), 32'(i % 2));
    wait_cw(c0 + 8);
    for (int i = 0; i < 8; i++)
      if (cw_hist.size() > c0 + i)
        chk($sformatf("rr_cw%0d", i), 32'(cw_hist[c0 + i]), {1'((i / 2) % 2), 1'(i % 2), cont_exp[i % 4]});
    check_sb();

    // Back-pressure during OUT_LO
    tick();
    c0 = cw_hist.size();
    cw_ready = 1'b0;
    send(1'b0, 8'h7E);
    k = 0;
    do begin @(negedge clk); k++; end while (!cw_valid && k < 50);
    bp_data = cw_data;
    chk("bp_first", {cw_valid, cw_src, cw_hi, bp_data}, {3'b100, 7'h5E});
    req1_data = 8'h0F; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {cw_valid, cw_data, enc_ena, req0_ready, req1_ready}, {1'b1, bp_data, 3'b000});
    end
    tick(); cw_ready = 1'b1;
    a0 = acc_log.size(); k = 0;
    while (acc_log.size() == a0 && k < 100) begin tick(); k++; end
    req1_valid = 1'b0;
    chk("bp_next_src", 32'(acc_log[acc_log.size() - 1]), 1);
    wait_cw(c0 + 4);
    check_sb();

    // Watchdog: encoder never answers
    tick();
    mute = 1'b1;
    c0 = cw_hist.size(); e0 = ena_cyc;
    send(1'b0, 8'h11);
    k = 0;
    while (ena_cyc == e0 && k < 20) begin tick(); k++; end
    e0 = ena_cyc;
    k = 0;
    while (!timeout_err && k < 40) begin tick(); k++; end
    chk("wd_lat", 32'(cyc - e0), 9);
    chk("wd_idle", {busy, cw_valid}, 0);
    chk("wd_no_cw", 32'(cw_hist.size()), 32'(c0));
    sb.delete();
    mute = 1'b0;
    send(1'b1, 8'h9C);
    wait_cw(c0 + 2);
    check_sb();
    chk("wd_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 0);

    // Clear in the same cycle as a new timeout: set wins
    mute = 1'b1;
    e0 = ena_cyc;
    send(1'b1, 8'h22);
    k = 0;
    while (ena_cyc == e0 && k < 20) begin tick(); k++; end
    e0 = ena_cyc;
    while (cyc < e0 + 8) tick();
    chk("wd_pre", 32'(timeout_err), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("set_beats_clr", 32'(timeout_err), 1);
    sb.delete();
    mute = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_alone", 32'(timeout_err), 0);

    // Async reset in WAIT_HI, then both pending: req0 first
    tick();
    c0 = cw_hist.size();
    send(1'b0, 8'h47);
    wait_cw(c0 + 1);
    mute = 1'b1;
    check_sb();
    tick();
    req0_data = 8'hB4; req1_data = 8'h6D;
    req0_valid = 1'b1; req1_valid = 1'b1;
    chk("whi_busy", {busy, enc_data}, {1'b1, 4'h4});
    #2 rst = 1'b1;
    #1 chk("arst_outs", {req0_ready, req1_ready, enc_ena, enc_data, cw_valid, cw_data, cw_src, cw_hi, busy}, 0);
    sb.delete();
    tick(); rst = 1'b0; mute = 1'b0;
    a0 = acc_log.size(); c0 = cw_hist.size(); k = 0;
    while (acc_log.size() == a0 && k < 50) begin tick(); k++; end
    req0_valid = 1'b0;
    chk("post_rst_first", 32'(acc_log.size() > a0 ? acc_log[a0] : 1'b1), 0);
    k = 0;
    while (acc_log.size() < a0 + 2 && k < 100) begin tick(); k++; end
    req1_valid = 1'b0;
    wait_cw(c0 + 4);
    check_sb();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
